sfifo_mc_enq_pkt_desc: RTL and testbench

Multi-channel synchronous FIFO for `enq_pkt_desc_type` descriptors, generalising the single-queue descriptor FIFO to `NUM_CH` independent queues that share one storage array. It sits between the enqueue classifier, which writes one descriptor per cycle tagged with a channel, and the per-channel scheduler, which reads one descriptor per cycle from a selected channel. Per-channel count, full, empty and almost-full status feed the scheduler and back-pressure logic.

---
 rtl/sfifo_mc_enq_pkt_desc_pkg.sv | 16 +
 rtl/sfifo_mc_enq_pkt_desc_ch_ctrl.sv | 88 ++++++++
 rtl/sfifo_mc_enq_pkt_desc.sv | 106 ++++++++++
 tb/tb_sfifo_mc_enq_pkt_desc.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/sfifo_mc_enq_pkt_desc_pkg.sv
// Shared types for the multi-channel descriptor FIFO.
// Holds the descriptor layout and the channel-count ceiling.
package sfifo_mc_enq_pkt_desc_pkg;

  localparam int SFIFO_MC_MAX_CH = 16;

  typedef struct packed {
    logic        drop;
    logic [2:0]  qos;
    logic [13:0] pkt_len;
    logic [15:0] buf_ptr;
  } enq_pkt_desc_type;

  localparam int DESC_W = $bits(enq_pkt_desc_type);

endpackage

// File: rtl/sfifo_mc_enq_pkt_desc_ch_ctrl.sv
// Per-channel pointer/count/status for the shared FIFO.
// Optional sticky error flag under SFIFO_MC_ERR_EN.
module sfifo_mc_ch_ctrl
  import sfifo_mc_enq_pkt_desc_pkg::*;
#(
  parameter int DEPTH_NBITS = 3,
  parameter int AFULL_LVL   = 6
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wr_i,
  input  logic                   rd_i,
  output logic                   wr_ok_o,
  output logic                   rd_ok_o,
  output logic [DEPTH_NBITS-1:0] wptr_o,
  output logic [DEPTH_NBITS-1:0] rptr_o,
  output logic [DEPTH_NBITS:0]   count_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic                   afull_o,
  output logic                   err_o
);

  localparam int CW = DEPTH_NBITS + 1;
  localparam logic [CW-1:0] DEPTH_C =
    CW'(1 << DEPTH_NBITS);
  localparam logic [CW-1:0] AFULL_C =
    CW'(AFULL_LVL);

  logic [DEPTH_NBITS-1:0] wptr_q;
  logic [DEPTH_NBITS-1:0] rptr_q;
  logic [CW-1:0]          count_q;
  logic [CW-1:0]          count_d;

  assign full_o  = (count_q == DEPTH_C);
  assign empty_o = (count_q == '0);
  assign afull_o = (count_q >= AFULL_C);

  assign wr_ok_o = wr_i & ~full_o;
  assign rd_ok_o = rd_i & ~empty_o;

  assign wptr_o  = wptr_q;
  assign rptr_o  = rptr_q;
  assign count_o = count_q;

  // Next occupancy: simultaneous push/pop cancels out.
  always_comb begin
    count_d = count_q;
    unique case ({wr_ok_o, rd_ok_o})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and count state, wrapping modulo depth.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (wr_ok_o) wptr_q <= wptr_q + DEPTH_NBITS'(1);
      if (rd_ok_o) rptr_q <= rptr_q + DEPTH_NBITS'(1);
      count_q <= count_d;
    end
  end

`ifdef SFIFO_MC_ERR_EN
  logic err_q;
  logic err_d;

  assign err_d = (wr_i & full_o) | (rd_i & empty_o);
  assign err_o = err_q;

  // Sticky flag for dropped writes and ignored reads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (err_d) begin
      err_q <= 1'b1;
    end
  end
`else
  assign err_o = 1'b0;
`endif

endmodule

// File: rtl/sfifo_mc_enq_pkt_desc.sv
// Multi-channel descriptor FIFO over one shared array.
// Build option: SFIFO_MC_ERR_EN enables sticky err flags.
module sfifo_mc_enq_pkt_desc
  import sfifo_mc_enq_pkt_desc_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int CH_NBITS    = 2,
  parameter int DEPTH_NBITS = 3,
  parameter int AFULL_LVL   = (2 ** DEPTH_NBITS) - 2
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           wr,
  input  logic [CH_NBITS-1:0]            wr_ch,
  input  enq_pkt_desc_type               din,
  input  logic                           rd,
  input  logic [CH_NBITS-1:0]            rd_ch,
  output enq_pkt_desc_type               dout,
  output logic                           dout_vld,
  output logic [NUM_CH*(DEPTH_NBITS+1)-1:0] count,
  output logic [NUM_CH-1:0]              full,
  output logic [NUM_CH-1:0]              empty,
  output logic [NUM_CH-1:0]              afull,
  output logic [NUM_CH-1:0]              err
);

  localparam int DEPTH = 2 ** DEPTH_NBITS;
  localparam int CW    = DEPTH_NBITS + 1;
  localparam int AW    = CH_NBITS + DEPTH_NBITS;

  if (NUM_CH < 2 || NUM_CH > SFIFO_MC_MAX_CH ||
      (2 ** CH_NBITS) != NUM_CH ||
      AFULL_LVL < 1 || AFULL_LVL > DEPTH)
  begin : g_bad_param
    $error("sfifo_mc_enq_pkt_desc: bad params");
  end

  logic [NUM_CH-1:0]      wr_req;
  logic [NUM_CH-1:0]      rd_req;
  logic [NUM_CH-1:0]      wr_ok;
  logic [NUM_CH-1:0]      rd_ok;
  logic [DEPTH_NBITS-1:0] wptr [NUM_CH];
  logic [DEPTH_NBITS-1:0] rptr [NUM_CH];

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [CW-1:0] cnt;

    assign wr_req[c] = wr & (wr_ch == CH_NBITS'(c));
    assign rd_req[c] = rd & (rd_ch == CH_NBITS'(c));

    sfifo_mc_ch_ctrl #(
      .DEPTH_NBITS (DEPTH_NBITS),
      .AFULL_LVL   (AFULL_LVL)
    ) u_ctrl (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_i    (wr_req[c]),
      .rd_i    (rd_req[c]),
      .wr_ok_o (wr_ok[c]),
      .rd_ok_o (rd_ok[c]),
      .wptr_o  (wptr[c]),
      .rptr_o  (rptr[c]),
      .count_o (cnt),
      .full_o  (full[c]),
      .empty_o (empty[c]),
      .afull_o (afull[c]),
      .err_o   (err[c])
    );

    assign count[c*CW +: CW] = cnt;
  end

  logic          wr_acc;
  logic          rd_acc;
  logic [AW-1:0] waddr;
  logic [AW-1:0] raddr;

  assign wr_acc = |wr_ok;
  assign rd_acc = |rd_ok;
  assign waddr  = {wr_ch, wptr[wr_ch]};
  assign raddr  = {rd_ch, rptr[rd_ch]};

  enq_pkt_desc_type mem_q [NUM_CH*DEPTH];
  enq_pkt_desc_type dout_q;
  logic             dout_vld_q;

  // Shared storage; contents are not reset.
  always_ff @(posedge clk) begin
    if (wr_acc) mem_q[waddr] <= din;
  end

  // Registered read port; dout holds when no read lands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_q     <= '0;
      dout_vld_q <= 1'b0;
    end else begin
      if (rd_acc) dout_q <= mem_q[raddr];
      dout_vld_q <= rd_acc;
    end
  end

  assign dout     = dout_q;
  assign dout_vld = dout_vld_q;

endmodule

// File: tb/tb_sfifo_mc_enq_pkt_desc.sv
// Self-checking bench for sfifo_mc_enq_pkt_desc.
// Queue-based reference model plus directed vectors.
module tb_sfifo_mc_enq_pkt_desc;
  import sfifo_mc_enq_pkt_desc_pkg::*;

  localparam int NCH   = 4;
  localparam int DEPTH = 8;
  localparam int AFL   = 6;
  localparam int CW    = 4;

  logic             clk   = 1'b0;
  logic             rst_n = 1'b0;
  logic             wr    = 1'b0;
  logic             rd    = 1'b0;
  logic [1:0]       wr_ch = '0;
  logic [1:0]       rd_ch = '0;
  enq_pkt_desc_type din   = '0;
  enq_pkt_desc_type dout;
  logic             dout_vld;
  logic [15:0]      count;
  logic [3:0]       full, empty, afull, err;

  always #5 clk = ~clk;

  sfifo_mc_enq_pkt_desc dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr       (wr),
    .wr_ch    (wr_ch),
    .din      (din),
    .rd       (rd),
    .rd_ch    (rd_ch),
    .dout     (dout),
    .dout_vld (dout_vld),
    .count    (count),
    .full     (full),
    .empty    (empty),
    .afull    (afull),
    .err      (err)
  );

  int n_pass = 0;
  int n_tot  = 0;

  enq_pkt_desc_type mq [NCH][$];
  enq_pkt_desc_type m_dout;
  logic             m_vld;
  logic [3:0]       m_err;

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h",
                  name, act, exp);
  endtask

  function automatic void model_reset();
    for (int c = 0; c < NCH; c++) mq[c].delete();
    m_dout = '0;
    m_vld  = 1'b0;
    m_err  = '0;
  endfunction

  function automatic enq_pkt_desc_type rdesc();
    logic [63:0] t;
    t = {$urandom(), $urandom()};
    return enq_pkt_desc_type'(t[DESC_W-1:0]);
  endfunction

  task automatic check_state(input string tag);
    logic [3:0] ef, ee, ea, er;
    for (int c = 0; c < NCH; c++) begin
      chk($sformatf("%s count[%0d]", tag, c),
          64'(count[c*CW +: CW]), 64'(mq[c].size()));
      ef[c] = (mq[c].size() == DEPTH);
      ee[c] = (mq[c].size() == 0);
      ea[c] = (mq[c].size() >= AFL);
    end
`ifdef SFIFO_MC_ERR_EN
    er = m_err;
`else
    er = '0;
`endif
    chk({tag, " full"},  64'(full),  64'(ef));
    chk({tag, " empty"}, 64'(empty), 64'(ee));
    chk({tag, " afull"}, 64'(afull), 64'(ea));
    chk({tag, " err"},   64'(err),   64'(er));
    chk({tag, " vld"},   64'(dout_vld), 64'(m_vld));
    chk({tag, " dout"},  64'(dout),  64'(m_dout));
  endtask

  task automatic cyc(input string tag,
                     input bit w, input logic [1:0] wc,
                     input enq_pkt_desc_type d,
                     input bit r, input logic [1:0] rc);
    bit wa, ra;
    wr = w; wr_ch = wc; din = d;
    rd = r; rd_ch = rc;
    wa = w && (mq[wc].size() < DEPTH);
    ra = r && (mq[rc].size() > 0);
    @(posedge clk);
    #1;
    if (ra) m_dout = mq[rc].pop_front();
    m_vld = ra;
    if (wa) mq[wc].push_back(d);
    if (w && !wa) m_err[wc] = 1'b1;
    if (r && !ra) m_err[rc] = 1'b1;
    wr = 1'b0;
    rd = 1'b0;
    check_state(tag);
  endtask

  typedef struct {
    bit               w;
    logic [1:0]       wc;
    enq_pkt_desc_type d;
    bit               r;
    logic [1:0]       rc;
    logic [15:0]      ecnt;
    bit               evld;
    enq_pkt_desc_type edout;
  } vec_t;

  vec_t tbl [9];
  enq_pkt_desc_type da, db, dc, dd, dx, z;

  initial begin
    da = '{drop:1'b0, qos:3'd1, pkt_len:14'd64,
           buf_ptr:16'h00a0};
    db = '{drop:1'b0, qos:3'd2, pkt_len:14'd128,
           buf_ptr:16'h00b1};
    dc = '{drop:1'b1, qos:3'd3, pkt_len:14'd1500,
           buf_ptr:16'h00c2};
    dd = '{drop:1'b0, qos:3'd7, pkt_len:14'd9000,
           buf_ptr:16'hd00d};
    z  = '0;

    tbl[0] = '{1, 2, da, 0, 0, 16'h0100, 0, z};
    tbl[1] = '{1, 2, db, 0, 0, 16'h0200, 0, z};
    tbl[2] = '{1, 2, dc, 0, 0, 16'h0300, 0, z};
    tbl[3] = '{0, 0, z,  1, 2, 16'h0200, 1, da};
    tbl[4] = '{0, 0, z,  1, 2, 16'h0100, 1, db};
    tbl[5] = '{0, 0, z,  1, 2, 16'h0000, 1, dc};
    tbl[6] = '{1, 1, dd, 1, 1, 16'h0010, 0, dc};
    tbl[7] = '{0, 0, z,  0, 0, 16'h0010, 0, dc};
    tbl[8] = '{0, 0, z,  1, 1, 16'h0000, 1, dd};

    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    check_state("por");
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 9; i++) begin
      cyc($sformatf("tbl%0d", i), tbl[i].w, tbl[i].wc,
          tbl[i].d, tbl[i].r, tbl[i].rc);
      chk($sformatf("tbl%0d cnt", i),
          64'(count), 64'(tbl[i].ecnt));
      chk($sformatf("tbl%0d vld", i),
          64'(dout_vld), 64'(tbl[i].evld));
      chk($sformatf("tbl%0d dout", i),
          64'(dout), 64'(tbl[i].edout));
    end

    for (int k = 1; k <= DEPTH; k++) begin
      cyc("fill0", 1, 0, rdesc(), 0, 0);
      chk($sformatf("afull0 k%0d", k),
          64'(afull[0]), 64'(k >= AFL));
      chk($sformatf("full0 k%0d", k),
          64'(full[0]), 64'(k == DEPTH));
    end
    cyc("drop0", 1, 0, rdesc(), 0, 0);
    chk("drop0 cnt", 64'(count[3:0]), 64'(DEPTH));
    for (int k = 0; k < DEPTH; k++)
      cyc("drain0", 0, 0, z, 1, 0);

    for (int k = 0; k < 4; k++)
      cyc("pre3", 1, 3, rdesc(), 0, 0);
    for (int k = 0; k < 20; k++) begin
      cyc("wr3rd3", 1, 3, rdesc(), 1, 3);
      chk("wr3rd3 cnt", 64'(count[15:12]), 64'd4);
    end

    for (int k = 0; k < 100; k++) begin
      if (k % 2 == 0) cyc("ilv", 1, 0, rdesc(), 1, 1);
      else            cyc("ilv", 1, 1, rdesc(), 1, 0);
    end

    for (int k = 0; k < 300; k++) begin
      cyc("rnd", ($urandom_range(0, 9) < 6),
          2'($urandom_range(0, 3)), rdesc(),
          ($urandom_range(0, 9) < 5),
          2'($urandom_range(0, 3)));
    end

    for (int c = 0; c < NCH; c++)
      while (mq[c].size() > 0)
        cyc("flush", 0, 0, z, 1, 2'(c));
    for (int k = 0; k < 6; k++)
      cyc("pre0", 1, 0, rdesc(), 0, 0);
    for (int k = 0; k < 3; k++)
      cyc("pre1", 1, 1, rdesc(), 0, 0);
    cyc("prerst", 0, 0, z, 1, 0);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_state("midrst");
    chk("midrst vld", 64'(dout_vld), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    dx = rdesc();
    cyc("postw", 1, 0, dx, 0, 0);
    cyc("postr", 0, 0, z, 1, 0);
    chk("post dout", 64'(dout), 64'(dx));

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
